// File: rtl/instr_fetch_unit_if.sv
// Bundles the instruction-memory request bus, the redirect input and the
// fetch-to-decode handshake. master = fetch unit side, slave = environment side.
interface instr_fetch_unit_if #(
  parameter int PC_W = 32
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [5:0]      if_opcode;
  logic [PC_W-1:0] if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_opcode, if_pc,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_opcode, if_pc,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues word fetches and hands each instruction to
// decode over a valid/ready handshake. Redirects override everything else.
module instr_fetch_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic              clk,
  input logic              rst_n,
  instr_fetch_unit_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] if_pc_q, if_pc_d;

  // A redirect discards any coincident ack or ready and restarts fetching.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if_pc_d = if_pc_q;
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc & ALIGN_MASK;
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (bus.imem_ack) begin
            instr_d = bus.imem_rdata;
            if_pc_d = pc_q;
            pc_d    = pc_q + PC_STEP;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.if_ready) state_d = S_FETCH;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC & ALIGN_MASK;
      instr_q <= '0;
      if_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      if_pc_q <= if_pc_d;
    end
  end

  // Outputs come only from state and registers, never straight from inputs.
  assign bus.imem_req  = (state_q == S_FETCH);
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = (state_q == S_HOLD);
  assign bus.if_instr  = instr_q;
  assign bus.if_opcode = instr_q[31:26];
  assign bus.if_pc     = if_pc_q;

endmodule
